// File: rtl/tcp_pkg.sv
// Shared TCP constants, FSM state encodings and one's-complement helpers
// for the TCP segment generator and its checksum datapath.
package tcp_pkg;

  localparam int FLAG_FIN = 0;
  localparam int FLAG_SYN = 1;
  localparam int FLAG_RST = 2;
  localparam int FLAG_PSH = 3;
  localparam int FLAG_ACK = 4;
  localparam int FLAG_URG = 5;
  localparam int FLAG_ECE = 6;
  localparam int FLAG_CWR = 7;

  localparam logic [7:0]  TCP_BASE_HDR_BYTES = 8'd20;
  localparam logic [7:0]  TCP_OPT_MSS_KIND   = 8'd2;
  localparam logic [7:0]  TCP_OPT_MSS_LEN    = 8'd4;
  localparam logic [7:0]  IP_PROTO_TCP       = 8'h06;
  localparam logic [15:0] IP_BASE_HDR_BYTES  = 16'd20;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CSUM    = 3'd1;
  localparam logic [2:0] ST_IP_HDR  = 3'd2;
  localparam logic [2:0] ST_HEADER  = 3'd3;
  localparam logic [2:0] ST_PAYLOAD = 3'd4;
  localparam logic [2:0] ST_PAD     = 3'd5;
  localparam logic [2:0] ST_DRAIN   = 3'd6;

  // End-around carry fold of a 17-bit partial sum; cannot re-overflow.
  function automatic logic [15:0] csum_fold(input logic [16:0] s);
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/inet_csum_accum.sv
// Internet one's-complement accumulator: clear, then one 16-bit word per
// valid cycle, carry folded back every cycle so sum is always final.
module inet_csum_accum
  import tcp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        valid,
  input  logic [15:0] word,
  output logic [15:0] sum
);

  // Accumulate with folded carry.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum <= 16'd0;
    end else if (valid) begin
      sum <= csum_fold({1'b0, sum} + {1'b0, word});
    end else begin
      sum <= sum;
    end
  end

endmodule

// File: rtl/tcp_segment_generator.sv
// Builds one TCP segment at a time: checksum pass, IP header handoff,
// TCP header serialisation, then payload passthrough with pad/drain repair.
module tcp_segment_generator
  import tcp_pkg::*;
#(
  parameter logic [7:0]  TTL         = 8'd64,
  parameter bit          MSS_OPT_EN  = 1'b1,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1460
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hdr_valid,
  output logic        o_hdr_ready,
  input  logic [31:0] i_seq_number,
  input  logic [31:0] i_ack_number,
  input  logic [15:0] i_source_port,
  input  logic [15:0] i_dest_port,
  input  logic [7:0]  i_flags,
  input  logic [15:0] i_window_size,
  input  logic        i_mss_en,
  input  logic [15:0] i_mss,
  input  logic [15:0] i_payload_len,
  input  logic [15:0] i_payload_sum,
  input  logic [31:0] i_src_ip,
  input  logic [31:0] i_dst_ip,
  input  logic [7:0]  s_axis_data_tdata,
  input  logic        s_axis_data_tvalid,
  input  logic        s_axis_data_tlast,
  output logic        s_axis_data_tready,
  output logic        m_ip_hdr_valid,
  input  logic        m_ip_hdr_ready,
  output logic [5:0]  m_ip_dscp,
  output logic [1:0]  m_ip_ecn,
  output logic [15:0] m_ip_length,
  output logic [7:0]  m_ip_ttl,
  output logic [7:0]  m_ip_protocol,
  output logic [31:0] m_ip_src_ip,
  output logic [31:0] m_ip_dst_ip,
  output logic [7:0]  m_ip_tdata,
  output logic        m_ip_tvalid,
  input  logic        m_ip_tready,
  output logic        m_ip_tlast,
  output logic        o_packet_done,
  output logic        o_len_err
);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [4:0]  widx;
  logic [31:0] seq, ack, src_ip, dst_ip;
  logic [15:0] sport, dport, window, mss, pay_len, pay_sum;
  logic [7:0]  flags;
  logic        mss_on;

  logic        hdr_fire, clamp, mss_req;
  logic [7:0]  hlen;
  logic [3:0]  offset;
  logic [15:0] tcp_len;
  logic [4:0]  last_widx;
  logic        hdr_last, pay_last, m_fire, s_fire;
  logic [15:0] csum_word, acc_sum, checksum;
  logic [7:0]  hdr_byte;

  assign mss_req   = i_mss_en & MSS_OPT_EN;
  assign hdr_fire  = i_hdr_valid & (state == ST_IDLE);
  assign clamp     = i_payload_len > MAX_PAYLOAD;
  assign hlen      = TCP_BASE_HDR_BYTES + {5'd0, mss_on, 2'b00};
  assign offset    = hlen[5:2];
  assign tcp_len   = {8'd0, hlen} + pay_len;
  assign last_widx = mss_on ? 5'd18 : 5'd16;
  assign checksum  = ~acc_sum;
  assign hdr_last  = cnt == ({8'd0, hlen} - 16'd1);
  assign pay_last  = cnt == (pay_len - 16'd1);
  assign m_fire    = m_ip_tvalid & m_ip_tready;
  assign s_fire    = s_axis_data_tvalid & s_axis_data_tready;

  assign o_hdr_ready    = state == ST_IDLE;
  assign m_ip_hdr_valid = state == ST_IP_HDR;
  assign m_ip_dscp      = 6'd0;
  assign m_ip_ecn       = 2'd0;
  assign m_ip_length    = IP_BASE_HDR_BYTES + tcp_len;
  assign m_ip_ttl       = TTL;
  assign m_ip_protocol  = IP_PROTO_TCP;
  assign m_ip_src_ip    = src_ip;
  assign m_ip_dst_ip    = dst_ip;

  assign o_packet_done = m_fire & m_ip_tlast;
  assign o_len_err     = (hdr_fire & clamp)
                       | ((state == ST_PAYLOAD) & m_fire & (s_axis_data_tlast ^ pay_last));

  // Latch the request; payload length is clamped here, the sum is kept as given.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      seq <= 32'd0; ack <= 32'd0; src_ip <= 32'd0; dst_ip <= 32'd0;
      sport <= 16'd0; dport <= 16'd0; window <= 16'd0; mss <= 16'd0;
      pay_len <= 16'd0; pay_sum <= 16'd0; flags <= 8'd0; mss_on <= 1'b0;
    end else if (hdr_fire) begin
      seq <= i_seq_number; ack <= i_ack_number;
      src_ip <= i_src_ip; dst_ip <= i_dst_ip;
      sport <= i_source_port; dport <= i_dest_port;
      window <= i_window_size; mss <= i_mss; flags <= i_flags;
      pay_len <= clamp ? MAX_PAYLOAD : i_payload_len;
      pay_sum <= i_payload_sum; mss_on <= mss_req;
    end else begin
      seq <= seq;
    end
  end

  // Word sequence for the checksum: pseudo-header, header (csum/urgent as 0), option, payload.
  always_comb begin
    csum_word = 16'd0;
    case (widx)
      5'd0:  csum_word = src_ip[31:16];
      5'd1:  csum_word = src_ip[15:0];
      5'd2:  csum_word = dst_ip[31:16];
      5'd3:  csum_word = dst_ip[15:0];
      5'd4:  csum_word = {8'd0, IP_PROTO_TCP};
      5'd5:  csum_word = tcp_len;
      5'd6:  csum_word = sport;
      5'd7:  csum_word = dport;
      5'd8:  csum_word = seq[31:16];
      5'd9:  csum_word = seq[15:0];
      5'd10: csum_word = ack[31:16];
      5'd11: csum_word = ack[15:0];
      5'd12: csum_word = {offset, 4'b0000, flags};
      5'd13: csum_word = window;
      5'd16: csum_word = mss_on ? {TCP_OPT_MSS_KIND, TCP_OPT_MSS_LEN} : pay_sum;
      5'd17: csum_word = mss;
      5'd18: csum_word = pay_sum;
      default: csum_word = 16'd0;
    endcase
  end

  inet_csum_accum u_csum (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (hdr_fire),
    .valid (state == ST_CSUM),
    .word  (csum_word),
    .sum   (acc_sum)
  );

  // Big-endian TCP header byte selected by the beat counter.
  always_comb begin
    hdr_byte = 8'd0;
    case (cnt[4:0])
      5'd0:  hdr_byte = sport[15:8];
      5'd1:  hdr_byte = sport[7:0];
      5'd2:  hdr_byte = dport[15:8];
      5'd3:  hdr_byte = dport[7:0];
      5'd4:  hdr_byte = seq[31:24];
      5'd5:  hdr_byte = seq[23:16];
      5'd6:  hdr_byte = seq[15:8];
      5'd7:  hdr_byte = seq[7:0];
      5'd8:  hdr_byte = ack[31:24];
      5'd9:  hdr_byte = ack[23:16];
      5'd10: hdr_byte = ack[15:8];
      5'd11: hdr_byte = ack[7:0];
      5'd12: hdr_byte = {offset, 4'b0000};
      5'd13: hdr_byte = flags;
      5'd14: hdr_byte = window[15:8];
      5'd15: hdr_byte = window[7:0];
      5'd16: hdr_byte = checksum[15:8];
      5'd17: hdr_byte = checksum[7:0];
      5'd20: hdr_byte = TCP_OPT_MSS_KIND;
      5'd21: hdr_byte = TCP_OPT_MSS_LEN;
      5'd22: hdr_byte = mss[15:8];
      5'd23: hdr_byte = mss[7:0];
      default: hdr_byte = 8'd0;
    endcase
  end

  // Output stream steering per state; payload is a combinational passthrough.
  always_comb begin
    m_ip_tdata         = 8'd0;
    m_ip_tvalid        = 1'b0;
    m_ip_tlast         = 1'b0;
    s_axis_data_tready = 1'b0;
    case (state)
      ST_HEADER: begin
        m_ip_tdata  = hdr_byte;
        m_ip_tvalid = 1'b1;
        m_ip_tlast  = hdr_last & (pay_len == 16'd0);
      end
      ST_PAYLOAD: begin
        m_ip_tdata         = s_axis_data_tdata;
        m_ip_tvalid        = s_axis_data_tvalid;
        s_axis_data_tready = m_ip_tready;
        m_ip_tlast         = pay_last;
      end
      ST_PAD: begin
        m_ip_tvalid = 1'b1;
        m_ip_tlast  = pay_last;
      end
      ST_DRAIN: begin
        s_axis_data_tready = 1'b1;
      end
      default: begin
        m_ip_tvalid = 1'b0;
      end
    endcase
  end

  // Segment FSM and beat/word counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      cnt   <= 16'd0;
      widx  <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hdr_fire) begin
            state <= ST_CSUM;
            widx  <= 5'd0;
            cnt   <= 16'd0;
          end
        end
        ST_CSUM: begin
          if (widx == last_widx) state <= ST_IP_HDR;
          else widx <= widx + 5'd1;
        end
        ST_IP_HDR: begin
          if (m_ip_hdr_ready) begin
            state <= ST_HEADER;
            cnt   <= 16'd0;
          end
        end
        ST_HEADER: begin
          if (m_fire) begin
            if (hdr_last) begin
              cnt   <= 16'd0;
              state <= (pay_len == 16'd0) ? ST_IDLE : ST_PAYLOAD;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (m_fire) begin
            if (pay_last) begin
              cnt   <= 16'd0;
              state <= s_axis_data_tlast ? ST_IDLE : ST_DRAIN;
            end else begin
              cnt <= cnt + 16'd1;
              if (s_axis_data_tlast) state <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          if (m_fire) begin
            if (pay_last) begin
              cnt   <= 16'd0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (s_fire && s_axis_data_tlast) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_segment_generator.sv
// Scoreboard bench for tcp_segment_generator: directed segments with
// hand-computed checksums, a negedge monitor pops and compares every beat.
module tb_tcp_segment_generator;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hdr_valid = 1'b0, hdr_ready;
  logic [31:0] seq_n = 32'd0, ack_n = 32'd0, src_ip = 32'h0A000002, dst_ip = 32'h0A000001;
  logic [15:0] sport = 16'd0, dport = 16'd0, win = 16'd0, mss = 16'd0, plen = 16'd0, psum = 16'd0;
  logic [7:0]  flags = 8'd0;
  logic        mss_en = 1'b0;
  logic [7:0]  s_tdata = 8'd0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic        ip_hdr_valid, ip_hdr_ready = 1'b1;
  logic [5:0]  ip_dscp;
  logic [1:0]  ip_ecn;
  logic [15:0] ip_length;
  logic [7:0]  ip_ttl, ip_proto, m_tdata;
  logic [31:0] ip_src, ip_dst;
  logic        m_tvalid, m_tready = 1'b1, m_tlast, done, len_err;

  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, beats = 0;
  bit bp = 1'b0;
  logic [8:0]  exp_q[$];
  logic [15:0] ipl_q[$];
  bit          val_q[$];
  logic [7:0]  seg[$];

  always #5 clk = ~clk;

  tcp_segment_generator dut (
    .i_clk(clk), .i_rst(rst), .i_hdr_valid(hdr_valid), .o_hdr_ready(hdr_ready),
    .i_seq_number(seq_n), .i_ack_number(ack_n), .i_source_port(sport), .i_dest_port(dport),
    .i_flags(flags), .i_window_size(win), .i_mss_en(mss_en), .i_mss(mss),
    .i_payload_len(plen), .i_payload_sum(psum), .i_src_ip(src_ip), .i_dst_ip(dst_ip),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid), .s_axis_data_tlast(s_tlast),
    .s_axis_data_tready(s_tready),
    .m_ip_hdr_valid(ip_hdr_valid), .m_ip_hdr_ready(ip_hdr_ready), .m_ip_dscp(ip_dscp),
    .m_ip_ecn(ip_ecn), .m_ip_length(ip_length), .m_ip_ttl(ip_ttl), .m_ip_protocol(ip_proto),
    .m_ip_src_ip(ip_src), .m_ip_dst_ip(ip_dst),
    .m_ip_tdata(m_tdata), .m_ip_tvalid(m_tvalid), .m_ip_tready(m_tready), .m_ip_tlast(m_tlast),
    .o_packet_done(done), .o_len_err(len_err)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One's-complement sum over pseudo-header plus received segment.
  function automatic logic [15:0] seg_sum(input bq_t b);
    logic [31:0] s;
    logic [15:0] w;
    s = 32'h0A00 + 32'h0002 + 32'h0A00 + 32'h0001 + 32'h0006 + 32'(b.size());
    for (int i = 0; i < b.size(); i += 2) begin
      w = {b[i], (i + 1 < b.size()) ? b[i+1] : 8'h00};
      s = s + {16'd0, w};
    end
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return s[15:0];
  endfunction

  function automatic bq_t hdr_bytes(input logic [15:0] sp, dp, input logic [31:0] sq, ak,
                                    input logic [7:0] fl, input logic [15:0] wn, cs,
                                    input bit mon, input logic [15:0] ms);
    bq_t q;
    q = '{sp[15:8], sp[7:0], dp[15:8], dp[7:0], sq[31:24], sq[23:16], sq[15:8], sq[7:0],
          ak[31:24], ak[23:16], ak[15:8], ak[7:0], mon ? 8'h60 : 8'h50, fl,
          wn[15:8], wn[7:0], cs[15:8], cs[7:0], 8'h00, 8'h00};
    if (mon) begin
      q.push_back(8'h02); q.push_back(8'h04); q.push_back(ms[15:8]); q.push_back(ms[7:0]);
    end
    return q;
  endfunction

  task automatic push_exp(input bq_t b, input bit last_at_end);
    for (int i = 0; i < b.size(); i++)
      exp_q.push_back({last_at_end && (i == b.size() - 1), b[i]});
  endtask

  task automatic send_req(input logic [15:0] sp, dp, input logic [31:0] sq, ak,
                          input logic [7:0] fl, input logic [15:0] wn, input logic me,
                          input logic [15:0] ms, pl, ps);
    int t;
    sport = sp; dport = dp; seq_n = sq; ack_n = ak; flags = fl; win = wn;
    mss_en = me; mss = ms; plen = pl; psum = ps; hdr_valid = 1'b1;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (hdr_ready) break;
    end
    if (t == 200) check("req_timeout", 128'(t), 128'd0);
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    seq_n = 32'hDEADBEEF; psum = 16'hFFFF; plen = 16'h7777;
  endtask

  task automatic drive_up(input bq_t b);
    int i = 0, g = 0;
    bit fire;
    s_tdata = b[0]; s_tlast = (b.size() == 1); s_tvalid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    while (i < b.size() && g < 5000) begin
      @(negedge clk);
      fire = s_tvalid & s_tready;
      @(posedge clk); #1;
      if (fire) i++;
      if (i < b.size()) begin
        s_tdata = b[i]; s_tlast = (i == b.size() - 1);
        s_tvalid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      g++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (g >= 5000) check("upstream_timeout", 128'(i), 128'(b.size()));
  endtask

  task automatic wait_done(input int target);
    for (int t = 0; t < 5000 && done_cnt < target; t++) begin
      @(posedge clk); #1;
    end
    check("done_count", 128'(done_cnt), 128'(target));
    check("exp_q_empty", 128'(exp_q.size()), 128'd0);
  endtask

  // Output backpressure generator.
  always begin
    @(posedge clk); #1;
    if (bp) begin
      m_tready = 1'($urandom_range(0, 1));
      ip_hdr_ready = ($urandom_range(0, 3) == 0);
    end else begin
      m_tready = 1'b1;
      ip_hdr_ready = 1'b1;
    end
  end

  // Monitor: compare IP header, each output beat, checksum validity, pulses.
  always @(negedge clk) begin
    if (rst) begin
      seg.delete();
    end else begin
      if (ip_hdr_valid) begin
        if (ipl_q.size() == 0) check("ip_unexpected", 128'd1, 128'd0);
        else begin
          check("ip_fields", {ip_length, ip_src, ip_dst, ip_ttl, ip_proto, ip_dscp, ip_ecn},
                {ipl_q[0], 32'h0A000002, 32'h0A000001, 8'd64, 8'h06, 6'd0, 2'd0});
          if (ip_hdr_ready) void'(ipl_q.pop_front());
        end
      end
      if (m_tvalid && m_tready) begin
        beats++;
        seg.push_back(m_tdata);
        if (exp_q.size() == 0) check("beat_unexpected", {m_tlast, m_tdata}, 128'h1FF);
        else check($sformatf("beat%0d", seg.size() - 1), {m_tlast, m_tdata}, exp_q.pop_front());
        if (m_tlast) begin
          if (val_q.size() != 0 && val_q.pop_front()) check("csum_verify", seg_sum(seg), 16'hFFFF);
          seg.delete();
        end
      end
      if (done) done_cnt++;
      if (len_err) err_cnt++;
    end
  end

  initial begin
    bq_t syn_h, ack_h, hello, hel, hello7, zeros;
    int base, t;
    syn_h  = hdr_bytes(16'h1234, 16'h0050, 32'h1, 32'h0, 8'h02, 16'h1000, 16'h619F, 1'b1, 16'd1460);
    ack_h  = hdr_bytes(16'h1234, 16'h0050, 32'h2, 32'h10, 8'h18, 16'h1000, 16'h355D, 1'b0, 16'd0);
    hello  = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    hel    = '{8'h68, 8'h65, 8'h6C};
    hello7 = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h21};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", {hdr_ready, ip_hdr_valid, m_tvalid, m_tlast, s_tready, done, len_err}, 7'b1000000);
    @(posedge clk); #1;

    // SYN with MSS, header only.
    ipl_q.push_back(16'd44); val_q.push_back(1'b1); push_exp(syn_h, 1'b1);
    send_req(16'h1234, 16'h0050, 32'h1, 32'h0, 8'h02, 16'h1000, 1'b1, 16'd1460, 16'd0, 16'd0);
    wait_done(1);

    // ACK+PSH with "hello", no backpressure then random backpressure.
    for (int k = 0; k < 2; k++) begin
      bp = (k == 1);
      ipl_q.push_back(16'd45); val_q.push_back(1'b1); push_exp(ack_h, 1'b0); push_exp(hello, 1'b1);
      send_req(16'h1234, 16'h0050, 32'h2, 32'h10, 8'h18, 16'h1000, 1'b0, 16'd0, 16'd5, 16'h43D2);
      drive_up(hello);
      wait_done(2 + k);
    end
    bp = 1'b0;
    check("len_err_none", 128'(err_cnt), 128'd0);

    // Early upstream tlast after 3 bytes: pad two zeros.
    ipl_q.push_back(16'd45); val_q.push_back(1'b0); push_exp(ack_h, 1'b0);
    push_exp('{8'h68, 8'h65, 8'h6C, 8'h00, 8'h00}, 1'b1);
    send_req(16'h1234, 16'h0050, 32'h2, 32'h10, 8'h18, 16'h1000, 1'b0, 16'd0, 16'd5, 16'h43D2);
    drive_up(hel);
    wait_done(4);
    check("len_err_short", 128'(err_cnt), 128'd1);

    // Seven upstream bytes for five declared: two drained.
    ipl_q.push_back(16'd45); val_q.push_back(1'b1); push_exp(ack_h, 1'b0); push_exp(hello, 1'b1);
    send_req(16'h1234, 16'h0050, 32'h2, 32'h10, 8'h18, 16'h1000, 1'b0, 16'd0, 16'd5, 16'h43D2);
    drive_up(hello7);
    wait_done(5);
    check("len_err_long", 128'(err_cnt), 128'd2);
    @(negedge clk);
    check("ready_after_drain", {hdr_ready, m_tvalid}, 2'b10);
    @(posedge clk); #1;

    // Oversize length clamps to 1460.
    for (int i = 0; i < 1460; i++) zeros.push_back(8'h00);
    ipl_q.push_back(16'd1500); val_q.push_back(1'b1);
    push_exp(hdr_bytes(16'h1234, 16'h0050, 32'h3, 32'h20, 8'h10, 16'h2000, 16'h6377, 1'b0, 16'd0), 1'b0);
    push_exp(zeros, 1'b1);
    send_req(16'h1234, 16'h0050, 32'h3, 32'h20, 8'h10, 16'h2000, 1'b0, 16'd0, 16'd1461, 16'd0);
    check("len_err_clamp", 128'(err_cnt), 128'd3);
    drive_up(zeros);
    wait_done(6);

    // Reset while header byte 8 is presented, then a full SYN.
    ipl_q.push_back(16'd45);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, ack_h[i]});
    base = beats;
    send_req(16'h1234, 16'h0050, 32'h2, 32'h10, 8'h18, 16'h1000, 1'b0, 16'd0, 16'd5, 16'h43D2);
    for (t = 0; t < 500 && beats < base + 8; t++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_beats", 128'(beats - base), 128'd8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", {hdr_ready, ip_hdr_valid, m_tvalid, m_tlast, s_tready}, 5'b10000);
    check("abort_exp_empty", 128'(exp_q.size()), 128'd0);
    @(posedge clk); #1;
    ipl_q.push_back(16'd44); val_q.push_back(1'b1); push_exp(syn_h, 1'b1);
    send_req(16'h1234, 16'h0050, 32'h1, 32'h0, 8'h02, 16'h1000, 1'b1, 16'd1460, 16'd0, 16'd0);
    wait_done(7);
    check("len_err_final", 128'(err_cnt), 128'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
